// File: rtl/rv32_instr_parser.sv
// Registered RV32I + RVC decoder: captures a fetch word and reports its name code, size and raw fields.
// Optional compressed decode is enabled by defining PARSER_RVC_EN; otherwise 16-bit words decode to NOP.
module rv32_instr_parser #(
  parameter int unsigned NAME_W = 7
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [31:0]       instr_raw,
  input  logic              in_valid,
  output logic              out_valid,
  output logic [31:0]       instruction,
  output logic [2:0]        size,
  output logic [NAME_W-1:0] name,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic              aluc,
  output logic              ebit,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [11:0]       i_imm,
  output logic [11:0]       s_imm,
  output logic [11:0]       b_imm,
  output logic [19:0]       u_imm,
  output logic [19:0]       j_imm,
  output logic [2:0]        c_ubits,
  output logic              c_12bit,
  output logic [1:0]        c_umbits,
  output logic [1:0]        c_lmbits,
  output logic [1:0]        c_lbits
);

  localparam int unsigned CODE_W = 7;

  // Base ISA name codes
  localparam logic [CODE_W-1:0] N_NOP    = 7'd0;
  localparam logic [CODE_W-1:0] N_LUI    = 7'd1;
  localparam logic [CODE_W-1:0] N_AUIPC  = 7'd2;
  localparam logic [CODE_W-1:0] N_JAL    = 7'd3;
  localparam logic [CODE_W-1:0] N_JALR   = 7'd4;
  localparam logic [CODE_W-1:0] N_BEQ    = 7'd5;
  localparam logic [CODE_W-1:0] N_BNE    = 7'd6;
  localparam logic [CODE_W-1:0] N_BLT    = 7'd7;
  localparam logic [CODE_W-1:0] N_BGE    = 7'd8;
  localparam logic [CODE_W-1:0] N_BLTU   = 7'd9;
  localparam logic [CODE_W-1:0] N_BGEU   = 7'd10;
  localparam logic [CODE_W-1:0] N_LB     = 7'd11;
  localparam logic [CODE_W-1:0] N_LH     = 7'd12;
  localparam logic [CODE_W-1:0] N_LW     = 7'd13;
  localparam logic [CODE_W-1:0] N_LBU    = 7'd14;
  localparam logic [CODE_W-1:0] N_LHU    = 7'd15;
  localparam logic [CODE_W-1:0] N_SB     = 7'd16;
  localparam logic [CODE_W-1:0] N_SH     = 7'd17;
  localparam logic [CODE_W-1:0] N_SW     = 7'd18;
  localparam logic [CODE_W-1:0] N_ADDI   = 7'd19;
  localparam logic [CODE_W-1:0] N_SLTI   = 7'd20;
  localparam logic [CODE_W-1:0] N_SLTIU  = 7'd21;
  localparam logic [CODE_W-1:0] N_XORI   = 7'd22;
  localparam logic [CODE_W-1:0] N_ORI    = 7'd23;
  localparam logic [CODE_W-1:0] N_ANDI   = 7'd24;
  localparam logic [CODE_W-1:0] N_SLLI   = 7'd25;
  localparam logic [CODE_W-1:0] N_SRLI   = 7'd26;
  localparam logic [CODE_W-1:0] N_SRAI   = 7'd27;
  localparam logic [CODE_W-1:0] N_ADD    = 7'd28;
  localparam logic [CODE_W-1:0] N_SUB    = 7'd29;
  localparam logic [CODE_W-1:0] N_SLL    = 7'd30;
  localparam logic [CODE_W-1:0] N_SLT    = 7'd31;
  localparam logic [CODE_W-1:0] N_SLTU   = 7'd32;
  localparam logic [CODE_W-1:0] N_XOR    = 7'd33;
  localparam logic [CODE_W-1:0] N_SRL    = 7'd34;
  localparam logic [CODE_W-1:0] N_SRA    = 7'd35;
  localparam logic [CODE_W-1:0] N_OR     = 7'd36;
  localparam logic [CODE_W-1:0] N_AND    = 7'd37;
  localparam logic [CODE_W-1:0] N_FENCE  = 7'd38;
  localparam logic [CODE_W-1:0] N_ECALL  = 7'd39;
  localparam logic [CODE_W-1:0] N_EBREAK = 7'd40;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [31:0]       instruction_q, instruction_d;
  logic [NAME_W-1:0] name_q, name_d;
  logic [2:0]        size_q, size_d;
  logic              out_valid_q, out_valid_d;

  logic [CODE_W-1:0] code32_c;
  logic [CODE_W-1:0] code16_c;
  logic              is32_c;
  logic [2:0]        raw_f3_c;
  logic              raw_aluc_c;

  assign is32_c     = (instr_raw[1:0] == 2'b11);
  assign raw_f3_c   = instr_raw[14:12];
  assign raw_aluc_c = instr_raw[30];

  // 32-bit decode keyed on {aluc, funct3, opcode}
  always_comb begin
    code32_c = N_NOP;
    case (instr_raw[6:0])
      OPC_LUI:   code32_c = N_LUI;
      OPC_AUIPC: code32_c = N_AUIPC;
      OPC_JAL:   code32_c = N_JAL;
      OPC_JALR:  if (raw_f3_c == 3'b000) code32_c = N_JALR;
      OPC_BRANCH: begin
        case (raw_f3_c)
          3'b000:  code32_c = N_BEQ;
          3'b001:  code32_c = N_BNE;
          3'b100:  code32_c = N_BLT;
          3'b101:  code32_c = N_BGE;
          3'b110:  code32_c = N_BLTU;
          3'b111:  code32_c = N_BGEU;
          default: code32_c = N_NOP;
        endcase
      end
      OPC_LOAD: begin
        case (raw_f3_c)
          3'b000:  code32_c = N_LB;
          3'b001:  code32_c = N_LH;
          3'b010:  code32_c = N_LW;
          3'b100:  code32_c = N_LBU;
          3'b101:  code32_c = N_LHU;
          default: code32_c = N_NOP;
        endcase
      end
      OPC_STORE: begin
        case (raw_f3_c)
          3'b000:  code32_c = N_SB;
          3'b001:  code32_c = N_SH;
          3'b010:  code32_c = N_SW;
          default: code32_c = N_NOP;
        endcase
      end
      OPC_OPIMM: begin
        case (raw_f3_c)
          3'b000:  code32_c = N_ADDI;
          3'b010:  code32_c = N_SLTI;
          3'b011:  code32_c = N_SLTIU;
          3'b100:  code32_c = N_XORI;
          3'b110:  code32_c = N_ORI;
          3'b111:  code32_c = N_ANDI;
          3'b001:  code32_c = raw_aluc_c ? N_NOP : N_SLLI;
          default: code32_c = raw_aluc_c ? N_SRAI : N_SRLI;
        endcase
      end
      OPC_OP: begin
        case ({raw_aluc_c, raw_f3_c})
          4'b0000: code32_c = N_ADD;
          4'b1000: code32_c = N_SUB;
          4'b0001: code32_c = N_SLL;
          4'b0010: code32_c = N_SLT;
          4'b0011: code32_c = N_SLTU;
          4'b0100: code32_c = N_XOR;
          4'b0101: code32_c = N_SRL;
          4'b1101: code32_c = N_SRA;
          4'b0110: code32_c = N_OR;
          4'b0111: code32_c = N_AND;
          default: code32_c = N_NOP;
        endcase
      end
      OPC_FENCE: if (raw_f3_c == 3'b000) code32_c = N_FENCE;
      OPC_SYSTEM: begin
        if (!raw_aluc_c && raw_f3_c == 3'b000)
          code32_c = instr_raw[20] ? N_EBREAK : N_ECALL;
      end
      default: code32_c = N_NOP;
    endcase
  end

`ifdef PARSER_RVC_EN
  localparam logic [CODE_W-1:0] N_C_ADDI4SPN = 7'd41;
  localparam logic [CODE_W-1:0] N_C_FLD      = 7'd42;
  localparam logic [CODE_W-1:0] N_C_LW       = 7'd43;
  localparam logic [CODE_W-1:0] N_C_FLW      = 7'd44;
  localparam logic [CODE_W-1:0] N_C_FSD      = 7'd45;
  localparam logic [CODE_W-1:0] N_C_SW       = 7'd46;
  localparam logic [CODE_W-1:0] N_C_FSW      = 7'd47;
  localparam logic [CODE_W-1:0] N_C_NOP      = 7'd48;
  localparam logic [CODE_W-1:0] N_C_ADDI     = 7'd49;
  localparam logic [CODE_W-1:0] N_C_JAL      = 7'd50;
  localparam logic [CODE_W-1:0] N_C_LI       = 7'd51;
  localparam logic [CODE_W-1:0] N_C_SRLI     = 7'd52;
  localparam logic [CODE_W-1:0] N_C_SRAI     = 7'd53;
  localparam logic [CODE_W-1:0] N_C_ANDI     = 7'd54;
  localparam logic [CODE_W-1:0] N_C_SUB      = 7'd55;
  localparam logic [CODE_W-1:0] N_C_XOR      = 7'd56;
  localparam logic [CODE_W-1:0] N_C_OR       = 7'd57;
  localparam logic [CODE_W-1:0] N_C_AND      = 7'd58;
  localparam logic [CODE_W-1:0] N_C_J        = 7'd59;
  localparam logic [CODE_W-1:0] N_C_BEQZ     = 7'd60;
  localparam logic [CODE_W-1:0] N_C_BNEZ     = 7'd61;
  localparam logic [CODE_W-1:0] N_C_SLLI     = 7'd62;
  localparam logic [CODE_W-1:0] N_C_FLDSP    = 7'd63;
  localparam logic [CODE_W-1:0] N_C_FLWSP    = 7'd64;
  localparam logic [CODE_W-1:0] N_C_JR       = 7'd65;
  localparam logic [CODE_W-1:0] N_C_MV       = 7'd66;
  localparam logic [CODE_W-1:0] N_C_EBREAK   = 7'd67;
  localparam logic [CODE_W-1:0] N_C_JALR     = 7'd68;
  localparam logic [CODE_W-1:0] N_C_ADD      = 7'd69;
  localparam logic [CODE_W-1:0] N_C_FSDSP    = 7'd70;
  localparam logic [CODE_W-1:0] N_C_SWSP     = 7'd71;
  localparam logic [CODE_W-1:0] N_C_FSWSP    = 7'd72;

  // 16-bit decode keyed on quadrant [1:0] and funct3 [15:13]
  always_comb begin
    code16_c = N_NOP;
    case (instr_raw[1:0])
      2'b00: begin
        case (instr_raw[15:13])
          3'b000:  code16_c = N_C_ADDI4SPN;
          3'b001:  code16_c = N_C_FLD;
          3'b010:  code16_c = N_C_LW;
          3'b011:  code16_c = N_C_FLW;
          3'b101:  code16_c = N_C_FSD;
          3'b110:  code16_c = N_C_SW;
          3'b111:  code16_c = N_C_FSW;
          default: code16_c = N_NOP;
        endcase
      end
      2'b01: begin
        case (instr_raw[15:13])
          3'b000:  code16_c = (instr_raw[12:2] == 11'd0) ? N_C_NOP : N_C_ADDI;
          3'b001:  code16_c = N_C_JAL;
          3'b010:  code16_c = N_C_LI;
          3'b101:  code16_c = N_C_J;
          3'b110:  code16_c = N_C_BEQZ;
          3'b111:  code16_c = N_C_BNEZ;
          3'b100: begin
            case (instr_raw[11:10])
              2'b00: code16_c = N_C_SRLI;
              2'b01: code16_c = N_C_SRAI;
              2'b10: code16_c = N_C_ANDI;
              default: begin
                if (!instr_raw[12]) begin
                  case (instr_raw[6:5])
                    2'b00:   code16_c = N_C_SUB;
                    2'b01:   code16_c = N_C_XOR;
                    2'b10:   code16_c = N_C_OR;
                    default: code16_c = N_C_AND;
                  endcase
                end
              end
            endcase
          end
          default: code16_c = N_NOP;
        endcase
      end
      2'b10: begin
        case (instr_raw[15:13])
          3'b000:  code16_c = N_C_SLLI;
          3'b001:  code16_c = N_C_FLDSP;
          3'b011:  code16_c = N_C_FLWSP;
          3'b101:  code16_c = N_C_FSDSP;
          3'b110:  code16_c = N_C_SWSP;
          3'b111:  code16_c = N_C_FSWSP;
          3'b100: begin
            if (!instr_raw[12])
              code16_c = (instr_raw[6:2] == 5'd0) ? N_C_JR : N_C_MV;
            else if (instr_raw[11:2] == 10'd0)
              code16_c = N_C_EBREAK;
            else if (instr_raw[6:2] == 5'd0)
              code16_c = N_C_JALR;
            else
              code16_c = N_C_ADD;
          end
          default: code16_c = N_NOP;
        endcase
      end
      default: code16_c = N_NOP;
    endcase
  end
`else
  assign code16_c = N_NOP;
`endif

  // Capture path: reset wins over in_valid; otherwise hold with out_valid dropping
  always_comb begin
    instruction_d = instruction_q;
    name_d        = name_q;
    size_d        = size_q;
    out_valid_d   = 1'b0;
    if (!nreset) begin
      instruction_d = 32'd0;
      name_d        = '0;
      size_d        = 3'd4;
    end else if (in_valid) begin
      instruction_d = instr_raw;
      name_d        = is32_c ? NAME_W'(code32_c) : NAME_W'(code16_c);
      size_d        = is32_c ? 3'd4 : 3'd2;
      out_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    instruction_q <= instruction_d;
    name_q        <= name_d;
    size_q        <= size_d;
    out_valid_q   <= out_valid_d;
  end

  assign instruction = instruction_q;
  assign name        = name_q;
  assign size        = size_q;
  assign out_valid   = out_valid_q;

  assign opcode   = instruction_q[6:0];
  assign funct3   = instruction_q[14:12];
  assign aluc     = instruction_q[30];
  assign ebit     = instruction_q[20];
  assign rd       = instruction_q[11:7];
  assign rs1      = instruction_q[19:15];
  assign rs2      = instruction_q[24:20];
  assign i_imm    = instruction_q[31:20];
  assign s_imm    = {instruction_q[31:25], instruction_q[11:7]};
  assign b_imm    = {instruction_q[31], instruction_q[7], instruction_q[30:25], instruction_q[11:8]};
  assign u_imm    = instruction_q[31:12];
  assign j_imm    = {instruction_q[31], instruction_q[19:12], instruction_q[20], instruction_q[30:21]};
  assign c_ubits  = instruction_q[15:13];
  assign c_12bit  = instruction_q[12];
  assign c_umbits = instruction_q[11:10];
  assign c_lmbits = instruction_q[6:5];
  assign c_lbits  = instruction_q[1:0];

endmodule

// File: tb/tb_rv32_instr_parser.sv
// Bench for rv32_instr_parser: directed vector table, hand sequences and random words vs a mask/match model.
module tb_rv32_instr_parser;

`ifdef PARSER_RVC_EN
  localparam bit RVC_EN = 1'b1;
`else
  localparam bit RVC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset;
  logic [31:0] instr_raw;
  logic        in_valid;
  logic        out_valid;
  logic [31:0] instruction;
  logic [2:0]  size;
  logic [6:0]  name;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        aluc, ebit;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] i_imm, s_imm, b_imm;
  logic [19:0] u_imm, j_imm;
  logic [2:0]  c_ubits;
  logic        c_12bit;
  logic [1:0]  c_umbits, c_lmbits, c_lbits;

  rv32_instr_parser #(.NAME_W(7)) dut (
    .clk(clk), .nreset(nreset), .instr_raw(instr_raw), .in_valid(in_valid),
    .out_valid(out_valid), .instruction(instruction), .size(size), .name(name),
    .opcode(opcode), .funct3(funct3), .aluc(aluc), .ebit(ebit),
    .rd(rd), .rs1(rs1), .rs2(rs2), .i_imm(i_imm), .s_imm(s_imm), .b_imm(b_imm),
    .u_imm(u_imm), .j_imm(j_imm), .c_ubits(c_ubits), .c_12bit(c_12bit),
    .c_umbits(c_umbits), .c_lmbits(c_lmbits), .c_lbits(c_lbits)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: ordered encoding patterns, first match wins
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          code;
    bit          rvc;
  } pat_t;
  pat_t pats[$];

  typedef struct {
    logic [31:0] w;
    int          nm;
  } vec_t;
  vec_t vecs[$];

  logic [31:0] exp_instr;
  int          exp_name;
  int          exp_size;
  bit          exp_valid;

  function automatic void add(logic [31:0] m, logic [31:0] v, int c, bit r);
    pats.push_back('{m, v, c, r});
  endfunction

  function automatic int ref_name(logic [31:0] w);
    foreach (pats[i]) begin
      if ((!pats[i].rvc || RVC_EN) && ((w & pats[i].mask) == pats[i].match))
        return pats[i].code;
    end
    return 0;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (exp_instr=0x%08h)", nm, act, exp, exp_instr);
    end
  endtask

  task automatic check_all();
    logic [31:0] e;
    e = exp_instr;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("instruction", instruction, e);
    check("size", 32'(size), 32'(exp_size));
    check("name", 32'(name), 32'(exp_name));
    check("opcode", 32'(opcode), 32'(e[6:0]));
    check("funct3", 32'(funct3), 32'(e[14:12]));
    check("aluc_ebit", 32'({aluc, ebit}), 32'({e[30], e[20]}));
    check("regs", 32'({rd, rs1, rs2}), 32'({e[11:7], e[19:15], e[24:20]}));
    check("i_imm", 32'(i_imm), 32'(e[31:20]));
    check("s_imm", 32'(s_imm), 32'({e[31:25], e[11:7]}));
    check("b_imm", 32'(b_imm), 32'({e[31], e[7], e[30:25], e[11:8]}));
    check("u_imm", 32'(u_imm), 32'(e[31:12]));
    check("j_imm", 32'(j_imm), 32'({e[31], e[19:12], e[20], e[30:21]}));
    check("c_fields", 32'({c_ubits, c_12bit, c_umbits, c_lmbits, c_lbits}),
          32'({e[15:13], e[12], e[11:10], e[6:5], e[1:0]}));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare
  task automatic step(logic [31:0] raw, bit v, bit rst_n);
    instr_raw = raw;
    in_valid  = v;
    nreset    = rst_n;
    @(posedge clk);
    if (!rst_n) begin
      exp_instr = 32'd0; exp_name = 0; exp_size = 4; exp_valid = 1'b0;
    end else if (v) begin
      exp_instr = raw; exp_name = ref_name(raw);
      exp_size  = (raw[1:0] == 2'b11) ? 4 : 2;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [6:0] opcs [11];
    // 32-bit patterns
    add(32'h7F, 32'h37, 1, 0);        add(32'h7F, 32'h17, 2, 0);
    add(32'h7F, 32'h6F, 3, 0);        add(32'h707F, 32'h67, 4, 0);
    add(32'h707F, 32'h0063, 5, 0);    add(32'h707F, 32'h1063, 6, 0);
    add(32'h707F, 32'h4063, 7, 0);    add(32'h707F, 32'h5063, 8, 0);
    add(32'h707F, 32'h6063, 9, 0);    add(32'h707F, 32'h7063, 10, 0);
    add(32'h707F, 32'h0003, 11, 0);   add(32'h707F, 32'h1003, 12, 0);
    add(32'h707F, 32'h2003, 13, 0);   add(32'h707F, 32'h4003, 14, 0);
    add(32'h707F, 32'h5003, 15, 0);   add(32'h707F, 32'h0023, 16, 0);
    add(32'h707F, 32'h1023, 17, 0);   add(32'h707F, 32'h2023, 18, 0);
    add(32'h707F, 32'h0013, 19, 0);   add(32'h707F, 32'h2013, 20, 0);
    add(32'h707F, 32'h3013, 21, 0);   add(32'h707F, 32'h4013, 22, 0);
    add(32'h707F, 32'h6013, 23, 0);   add(32'h707F, 32'h7013, 24, 0);
    add(32'h4000707F, 32'h1013, 25, 0);       add(32'h4000707F, 32'h5013, 26, 0);
    add(32'h4000707F, 32'h40005013, 27, 0);   add(32'h4000707F, 32'h0033, 28, 0);
    add(32'h4000707F, 32'h40000033, 29, 0);   add(32'h4000707F, 32'h1033, 30, 0);
    add(32'h4000707F, 32'h2033, 31, 0);       add(32'h4000707F, 32'h3033, 32, 0);
    add(32'h4000707F, 32'h4033, 33, 0);       add(32'h4000707F, 32'h5033, 34, 0);
    add(32'h4000707F, 32'h40005033, 35, 0);   add(32'h4000707F, 32'h6033, 36, 0);
    add(32'h4000707F, 32'h7033, 37, 0);       add(32'h707F, 32'h000F, 38, 0);
    add(32'h4010707F, 32'h73, 39, 0);         add(32'h4010707F, 32'h00100073, 40, 0);
    // 16-bit patterns
    add(32'hE003, 32'h0000, 41, 1);  add(32'hE003, 32'h2000, 42, 1);
    add(32'hE003, 32'h4000, 43, 1);  add(32'hE003, 32'h6000, 44, 1);
    add(32'hE003, 32'hA000, 45, 1);  add(32'hE003, 32'hC000, 46, 1);
    add(32'hE003, 32'hE000, 47, 1);  add(32'hFFFF, 32'h0001, 48, 1);
    add(32'hE003, 32'h0001, 49, 1);  add(32'hE003, 32'h2001, 50, 1);
    add(32'hE003, 32'h4001, 51, 1);  add(32'hEC03, 32'h8001, 52, 1);
    add(32'hEC03, 32'h8401, 53, 1);  add(32'hEC03, 32'h8801, 54, 1);
    add(32'hFC63, 32'h8C01, 55, 1);  add(32'hFC63, 32'h8C21, 56, 1);
    add(32'hFC63, 32'h8C41, 57, 1);  add(32'hFC63, 32'h8C61, 58, 1);
    add(32'hE003, 32'hA001, 59, 1);  add(32'hE003, 32'hC001, 60, 1);
    add(32'hE003, 32'hE001, 61, 1);  add(32'hE003, 32'h0002, 62, 1);
    add(32'hE003, 32'h2002, 63, 1);  add(32'hE003, 32'h6002, 64, 1);
    add(32'hF07F, 32'h8002, 65, 1);  add(32'hF003, 32'h8002, 66, 1);
    add(32'hFFFF, 32'h9002, 67, 1);  add(32'hF07F, 32'h9002, 68, 1);
    add(32'hF003, 32'h9002, 69, 1);  add(32'hE003, 32'hA002, 70, 1);
    add(32'hE003, 32'hC002, 71, 1);  add(32'hE003, 32'hE002, 72, 1);

    // Directed vectors with hand-derived name codes
    vecs.push_back('{32'h00500093, 19});
    vecs.push_back('{32'h40208033, 29});
    vecs.push_back('{32'h00100073, 40});
    vecs.push_back('{32'h00000073, 39});
    vecs.push_back('{32'h40000073, 0});
    vecs.push_back('{32'h008000EF, 3});
    vecs.push_back('{32'h0000007F, 0});
    vecs.push_back('{32'h40001013, 0});
    vecs.push_back('{32'h40005013, 27});
    vecs.push_back('{32'hFE20DCE3, 8});
    vecs.push_back('{32'h0FF0000F, 38});
    vecs.push_back('{32'h00001067, 0});
    vecs.push_back('{32'h00000001, RVC_EN ? 48 : 0});
    vecs.push_back('{32'h0000908A, RVC_EN ? 69 : 0});
    vecs.push_back('{32'h00000000, RVC_EN ? 41 : 0});
    vecs.push_back('{32'h00000005, RVC_EN ? 49 : 0});
    vecs.push_back('{32'h00006085, 0});
    vecs.push_back('{32'h00004082, 0});
    vecs.push_back('{32'h00008082, RVC_EN ? 65 : 0});
    vecs.push_back('{32'h0000808A, RVC_EN ? 66 : 0});
    vecs.push_back('{32'h00009002, RVC_EN ? 67 : 0});
    vecs.push_back('{32'h00009082, RVC_EN ? 68 : 0});
    vecs.push_back('{32'h00008C21, RVC_EN ? 56 : 0});
    vecs.push_back('{32'h00009C21, 0});

    // Reset state
    instr_raw = 32'd0; in_valid = 1'b0; nreset = 1'b0;
    exp_instr = 32'd0; exp_name = 0; exp_size = 4; exp_valid = 1'b0;
    step(32'hFFFF_FFFF, 1'b1, 1'b0);
    step(32'd0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      step(vecs[i].w, 1'b1, 1'b1);
      check("vec_name", 32'(name), 32'(vecs[i].nm));
    end

    // Field spot checks from the directed sequence
    step(32'h00500093, 1'b1, 1'b1);
    check("addi_fields", 32'({rd, rs1, i_imm}), 32'({5'd1, 5'd0, 12'h005}));
    step(32'h40208033, 1'b1, 1'b1);
    check("sub_regs", 32'({rd, rs1, rs2}), 32'({5'd0, 5'd1, 5'd2}));
    step(32'h008000EF, 1'b1, 1'b1);
    check("jal_fields", 32'({rd, j_imm}), 32'({5'd1, 20'h00004}));

    // Hold without in_valid, then reset colliding with in_valid
    step(32'h00000001, 1'b0, 1'b1);
    check("hold_name", 32'(name), 32'd3);
    step(32'h00500093, 1'b1, 1'b1);
    step(32'h40208033, 1'b1, 1'b0);
    check("rst_over_valid", 32'({out_valid, size, name}), 32'({1'b0, 3'd4, 7'd0}));
    check("rst_instr", instruction, 32'd0);

    // Random words, biased toward real opcodes
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 1) == 0) w[6:0] = opcs[$urandom_range(0, 10)];
      step(w, $urandom_range(0, 3) != 0, $urandom_range(0, 49) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
